// File: rtl/avr_hvpp_sequencer_pkg.sv
// Shared definitions for the AVR high-voltage parallel programming sequencer:
// opcode values, FSM state encoding, control-pin grouping and pin defaults.
package avr_hvpp_sequencer_pkg;

  localparam logic [3:0] OP_LOAD_CMD     = 4'd0;
  localparam logic [3:0] OP_LOAD_ADDR_LO = 4'd1;
  localparam logic [3:0] OP_LOAD_ADDR_HI = 4'd2;
  localparam logic [3:0] OP_LOAD_DATA_LO = 4'd3;
  localparam logic [3:0] OP_LOAD_DATA_HI = 4'd4;
  localparam logic [3:0] OP_PAGEL        = 4'd5;
  localparam logic [3:0] OP_WRITE        = 4'd6;
  localparam logic [3:0] OP_READ         = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Mode-select lines that stay stable around a strobe.
  typedef struct packed {
    logic xa1;
    logic xa0;
    logic bs1;
    logic bs2;
  } ctl_t;

  localparam ctl_t CTL_RESET  = 4'b0000;
  localparam logic OE_N_RESET = 1'b1;
  localparam logic WR_N_RESET = 1'b1;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op <= OP_LOAD_DATA_HI);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_READ);
  endfunction

  // XA/BS pattern for a legal opcode; BS bits of PAGEL/WRITE/READ come from the data byte.
  function automatic ctl_t op_ctl(input logic [3:0] op, input logic [7:0] data);
    ctl_t c;
    c = CTL_RESET;
    case (op)
      OP_LOAD_CMD:     c.xa1 = 1'b1;
      OP_LOAD_ADDR_LO: c = CTL_RESET;
      OP_LOAD_ADDR_HI: c.bs1 = 1'b1;
      OP_LOAD_DATA_LO: c.xa0 = 1'b1;
      OP_LOAD_DATA_HI: begin
        c.xa0 = 1'b1;
        c.bs1 = 1'b1;
      end
      OP_PAGEL:        c.bs1 = data[0];
      OP_WRITE, OP_READ: begin
        c.bs1 = data[0];
        c.bs2 = data[1];
      end
      default:         c = CTL_RESET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hvpp_delay_counter.sv
// Shared down-counter for setup, strobe, RDY blanking and RDY timeout phases.
// A load of N makes the zero flag rise N cycles later; it then holds at zero.
module hvpp_delay_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/avr_hvpp_sequencer.sv
// HVPP pin sequencer: turns one host opcode+byte into a timed XA/BS setup,
// strobe, hold and (for WRITE) RDY/BSY wait. All pin outputs are registered.
module avr_hvpp_sequencer
  import avr_hvpp_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned RDY_TIMEOUT = 65535,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  output logic [7:0] rd_data,
  input  logic       dut_rdy,
  input  logic [7:0] dut_data_in,
  output logic [7:0] dut_data_out,
  output logic       dut_data_oe,
  output logic       dut_oe_n,
  output logic       dut_wr_n,
  output logic       dut_xtal,
  output logic       dut_pagel,
  output logic       dut_bs1,
  output logic       dut_bs2,
  output logic       dut_xa0,
  output logic       dut_xa1
);

  // Counter reload values: a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 32'd1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] TOUT_LD  = CNT_W'(RDY_TIMEOUT - 32'd1);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       blank_q, blank_d;
  logic       rdy_meta_q, rdy_sync_q;
  logic       cmd_ready_q, cmd_ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       oe_n_q, oe_n_d;
  logic       wr_n_q, wr_n_d;
  logic       xtal_q, xtal_d;
  logic       pagel_q, pagel_d;
  ctl_t       ctl_q, ctl_d;

  logic             strobe_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;

  hvpp_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state, counter control and next values of every registered pin.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    blank_d    = blank_q;
    rd_data_d  = rd_data_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    ctl_d      = ctl_q;
    strobe_s   = 1'b0;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    cnt_dec_s  = 1'b0;
    if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          err_d = 1'b0;
          if (!op_is_legal(cmd_op)) begin
            // Illegal opcode: flag it and finish without touching any pin.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            ctl_d      = op_ctl(cmd_op, cmd_data);
            state_d    = ST_SETUP;
            cnt_load_s = 1'b1;
            cnt_val_s  = SETUP_LD;
            if (op_is_load(cmd_op)) begin
              data_out_d = cmd_data;
              data_oe_d  = 1'b1;
            end else if (cmd_op == OP_READ) begin
              // Release the bus well before /OE falls.
              data_oe_d = 1'b0;
            end else begin
              data_oe_d = data_oe_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_zero_s) begin
          state_d    = ST_STROBE;
          strobe_s   = 1'b1;
          cnt_load_s = 1'b1;
          cnt_val_s  = PULSE_LD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_zero_s) begin
          state_d = ST_HOLD;
          if (op_q == OP_READ) begin
            rd_data_d = dut_data_in;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
          strobe_s  = 1'b1;
          cnt_dec_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (op_q == OP_WRITE) begin
          // Blank RDY for SETUP_CYC cycles so the BSY fall is not missed.
          state_d    = ST_WAIT_RDY;
          blank_d    = 1'b1;
          cnt_load_s = 1'b1;
          cnt_val_s  = SETUP_LD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_RDY: begin
        if (blank_q) begin
          if (cnt_zero_s) begin
            blank_d    = 1'b0;
            cnt_load_s = 1'b1;
            cnt_val_s  = TOUT_LD;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end else if (rdy_sync_q) begin
          state_d = ST_DONE;
        end else if (cnt_zero_s) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
      end
    endcase

    xtal_d      = strobe_s & op_is_load(op_q);
    pagel_d     = strobe_s & (op_q == OP_PAGEL);
    wr_n_d      = ~(strobe_s & (op_q == OP_WRITE));
    oe_n_d      = ~(strobe_s & (op_q == OP_READ));
    done_d      = (state_d == ST_DONE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, RDY synchroniser and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD_CMD;
      blank_q     <= 1'b0;
      rdy_meta_q  <= 1'b0;
      rdy_sync_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= 8'h00;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      oe_n_q      <= OE_N_RESET;
      wr_n_q      <= WR_N_RESET;
      xtal_q      <= 1'b0;
      pagel_q     <= 1'b0;
      ctl_q       <= CTL_RESET;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      blank_q     <= blank_d;
      rdy_meta_q  <= dut_rdy;
      rdy_sync_q  <= rdy_meta_q;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      oe_n_q      <= oe_n_d;
      wr_n_q      <= wr_n_d;
      xtal_q      <= xtal_d;
      pagel_q     <= pagel_d;
      ctl_q       <= ctl_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rd_data      = rd_data_q;
  assign dut_data_out = data_out_q;
  assign dut_data_oe  = data_oe_q;
  assign dut_oe_n     = oe_n_q;
  assign dut_wr_n     = wr_n_q;
  assign dut_xtal     = xtal_q;
  assign dut_pagel    = pagel_q;
  assign dut_bs1      = ctl_q.bs1;
  assign dut_bs2      = ctl_q.bs2;
  assign dut_xa0      = ctl_q.xa0;
  assign dut_xa1      = ctl_q.xa1;

endmodule
